// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative write-back L1 cache: hit service, dirty-victim
// writeback and line allocation, plus saturating hit/miss statistics.
module cache_control #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic                 i_hit0,
    input  logic                 i_hit1,
    input  logic                 i_lru,
    input  logic                 i_victim_dirty,
    input  logic                 i_pmem_resp,
    output logic                 o_mem_resp,
    output logic                 o_pmem_read,
    output logic                 o_pmem_write,
    output logic                 o_pmem_address_sel,
    output logic                 o_way_sel,
    output logic                 o_load_data0,
    output logic                 o_load_data1,
    output logic                 o_data_in_sel,
    output logic                 o_load_tag0,
    output logic                 o_load_tag1,
    output logic                 o_set_dirty0,
    output logic                 o_set_dirty1,
    output logic                 o_clr_dirty0,
    output logic                 o_clr_dirty1,
    output logic                 o_load_lru,
    output logic                 o_lru_in,
    output logic [CNT_WIDTH-1:0] o_hit_count,
    output logic [CNT_WIDTH-1:0] o_miss_count
);

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e               r_state;
    logic                 r_miss_pend;
    logic [CNT_WIDTH-1:0] r_hit_count;
    logic [CNT_WIDTH-1:0] r_miss_count;

    logic w_req;
    logic w_hit;

    assign w_req        = i_mem_read | i_mem_write;
    assign w_hit        = i_hit0 | i_hit1;
    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_miss_pend  <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!w_req) begin
                        r_miss_pend <= 1'b0;
                    end else if (w_hit) begin
                        // A hit that follows our own allocation is not a new hit.
                        r_miss_pend <= 1'b0;
                        if (!r_miss_pend && r_hit_count != CntMax) begin
                            r_hit_count <= r_hit_count + 1'b1;
                        end
                    end else begin
                        r_miss_pend <= 1'b1;
                        if (r_miss_count != CntMax) begin
                            r_miss_count <= r_miss_count + 1'b1;
                        end
                        r_state <= i_victim_dirty ? StWriteback : StAllocate;
                    end
                end
                StWriteback: begin
                    if (i_pmem_resp) begin
                        r_state <= w_req ? StAllocate : StIdle;
                    end
                end
                StAllocate: begin
                    if (i_pmem_resp) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_mem_resp         = 1'b0;
        o_pmem_read        = 1'b0;
        o_pmem_write       = 1'b0;
        o_pmem_address_sel = 1'b0;
        o_way_sel          = 1'b0;
        o_load_data0       = 1'b0;
        o_load_data1       = 1'b0;
        o_data_in_sel      = 1'b0;
        o_load_tag0        = 1'b0;
        o_load_tag1        = 1'b0;
        o_set_dirty0       = 1'b0;
        o_set_dirty1       = 1'b0;
        o_clr_dirty0       = 1'b0;
        o_clr_dirty1       = 1'b0;
        o_load_lru         = 1'b0;
        o_lru_in           = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req && w_hit) begin
                    o_mem_resp = 1'b1;
                    o_way_sel  = i_hit1;
                    o_load_lru = 1'b1;
                    o_lru_in   = ~i_hit1;
                    if (i_mem_write) begin
                        o_data_in_sel = 1'b0;
                        o_load_data0  = ~i_hit1;
                        o_load_data1  = i_hit1;
                        o_set_dirty0  = ~i_hit1;
                        o_set_dirty1  = i_hit1;
                    end
                end
            end
            StWriteback: begin
                o_pmem_write       = 1'b1;
                o_pmem_address_sel = 1'b1;
                o_way_sel          = i_lru;
            end
            StAllocate: begin
                o_pmem_read        = 1'b1;
                o_pmem_address_sel = 1'b0;
                if (i_pmem_resp) begin
                    o_data_in_sel = 1'b1;
                    o_load_data0  = ~i_lru;
                    o_load_data1  = i_lru;
                    o_load_tag0   = ~i_lru;
                    o_load_tag1   = i_lru;
                    o_clr_dirty0  = ~i_lru;
                    o_clr_dirty1  = i_lru;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// Randomised bench for cache_control: a tiny one-set datapath/memory model drives the hit inputs,
// expected transactions go into a scoreboard queue checked by a separate monitor on mem_resp.
module tb_cache_control;

    localparam int unsigned CW  = 4;
    localparam int          MAX = (1 << CW) - 1;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic i_hit0 = 1'b0, i_hit1 = 1'b0, i_lru = 1'b0, i_victim_dirty = 1'b0, i_pmem_resp = 1'b0;
    logic o_mem_resp, o_pmem_read, o_pmem_write, o_pmem_address_sel, o_way_sel;
    logic o_load_data0, o_load_data1, o_data_in_sel, o_load_tag0, o_load_tag1;
    logic o_set_dirty0, o_set_dirty1, o_clr_dirty0, o_clr_dirty1, o_load_lru, o_lru_in;
    logic [CW-1:0] o_hit_count, o_miss_count;

    cache_control #(.CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_hit0(i_hit0), .i_hit1(i_hit1), .i_lru(i_lru), .i_victim_dirty(i_victim_dirty),
        .i_pmem_resp(i_pmem_resp), .o_mem_resp(o_mem_resp), .o_pmem_read(o_pmem_read),
        .o_pmem_write(o_pmem_write), .o_pmem_address_sel(o_pmem_address_sel),
        .o_way_sel(o_way_sel), .o_load_data0(o_load_data0), .o_load_data1(o_load_data1),
        .o_data_in_sel(o_data_in_sel), .o_load_tag0(o_load_tag0), .o_load_tag1(o_load_tag1),
        .o_set_dirty0(o_set_dirty0), .o_set_dirty1(o_set_dirty1), .o_clr_dirty0(o_clr_dirty0),
        .o_clr_dirty1(o_clr_dirty1), .o_load_lru(o_load_lru), .o_lru_in(o_lru_in),
        .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int unsigned start;
        int          lat;
        bit          wr;
        bit          way;
        bit          miss;
        int          hits;
        int          misses;
        int          n_pw;
        int          n_pr;
    } exp_t;

    exp_t sb[$];

    // Monitor: accumulates per-request activity, compares against the scoreboard on mem_resp.
    int       a_pw = 0, a_pr = 0, a_bad = 0;
    bit [1:0] a_tag = 2'b00, a_clr = 2'b00, a_pld = 2'b00;

    always @(negedge i_clk) begin
        if (i_rst || !(i_mem_read || i_mem_write)) begin
            a_pw = 0; a_pr = 0; a_bad = 0; a_tag = 2'b00; a_clr = 2'b00; a_pld = 2'b00;
        end else begin
            if (o_pmem_write) a_pw++;
            if (o_pmem_read) a_pr++;
            if (o_pmem_write && o_pmem_read) a_bad++;
            if (o_pmem_write && (!o_pmem_address_sel || o_way_sel != i_lru)) a_bad++;
            if (o_pmem_read && o_pmem_address_sel) a_bad++;
            a_tag |= {o_load_tag1, o_load_tag0};
            a_clr |= {o_clr_dirty1, o_clr_dirty0};
            if (o_data_in_sel) a_pld |= {o_load_data1, o_load_data0};
            if (o_mem_resp) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    bit [1:0] wmask;
                    bit [1:0] mmask;
                    e = sb.pop_front();
                    wmask = e.wr ? (2'b01 << e.way) : 2'b00;
                    mmask = e.miss ? (2'b01 << e.way) : 2'b00;
                    chk("latency", int'(cyc - e.start), e.lat);
                    chk("way_sel", int'(o_way_sel), int'(e.way));
                    chk("load_lru", int'(o_load_lru), 1);
                    chk("lru_in", int'(o_lru_in), int'(!e.way));
                    chk("hit_load_data", int'({o_load_data1, o_load_data0}), int'(wmask));
                    chk("hit_set_dirty", int'({o_set_dirty1, o_set_dirty0}), int'(wmask));
                    if (e.wr) chk("hit_data_in_sel", int'(o_data_in_sel), 0);
                    chk("pmem_write_cycles", a_pw, e.n_pw);
                    chk("pmem_read_cycles", a_pr, e.n_pr);
                    chk("pmem_protocol", a_bad, 0);
                    chk("alloc_load_tag", int'(a_tag), int'(mmask));
                    chk("alloc_clr_dirty", int'(a_clr), int'(mmask));
                    chk("alloc_load_data", int'(a_pld), int'(mmask));
                    chk("hit_count", int'(o_hit_count), e.hits);
                    chk("miss_count", int'(o_miss_count), e.misses);
                end
                a_pw = 0; a_pr = 0; a_bad = 0; a_tag = 2'b00; a_clr = 2'b00; a_pld = 2'b00;
            end
        end
    end

    // Datapath/memory model: which way holds the requested line (2 = none), dirty bits, LRU.
    int       m_present = 2;
    bit [1:0] m_dirty = 2'b00;
    bit       m_lru = 1'b0;
    int       tp_w = 1, tp_r = 1, pcnt = 0;
    int       exp_hits = 0, exp_misses = 0;
    bit       cap_resp, cap_any;
    bit [1:0] cap_tag, cap_set, cap_clr;

    task automatic drive_dp();
        i_hit0         = (m_present == 0);
        i_hit1         = (m_present == 1);
        i_lru          = m_lru;
        i_victim_dirty = m_dirty[m_lru];
    endtask

    // One clock: sample at negedge, then update model and memory responder just after posedge.
    task automatic step();
        @(negedge i_clk);
        cap_resp = o_mem_resp;
        cap_any  = |{o_mem_resp, o_pmem_read, o_pmem_write, o_pmem_address_sel, o_way_sel,
                     o_load_data0, o_load_data1, o_data_in_sel, o_load_tag0, o_load_tag1,
                     o_set_dirty0, o_set_dirty1, o_clr_dirty0, o_clr_dirty1, o_load_lru, o_lru_in};
        cap_tag  = {o_load_tag1, o_load_tag0};
        cap_set  = {o_set_dirty1, o_set_dirty0};
        cap_clr  = {o_clr_dirty1, o_clr_dirty0};
        @(posedge i_clk);
        #1;
        if (cap_tag[0]) m_present = 0;
        if (cap_tag[1]) m_present = 1;
        m_dirty = (m_dirty | cap_set) & ~cap_clr;
        if (o_pmem_read || o_pmem_write) begin
            pcnt++;
            i_pmem_resp = (pcnt >= (o_pmem_write ? tp_w : tp_r));
            if (i_pmem_resp) pcnt = 0;
        end else begin
            pcnt = 0;
            i_pmem_resp = 1'b0;
        end
        drive_dp();
    endtask

    function automatic int sat_inc(input int v);
        return (v >= MAX) ? MAX : v + 1;
    endfunction

    task automatic run_txn(input bit miss, input bit way, input bit wr, input bit rd,
                           input bit dirty, input int tpw, input int tpr);
        exp_t e;
        bit   got;
        m_lru     = miss ? way : 1'($urandom_range(1));
        m_present = miss ? 2 : int'(way);
        m_dirty   = 2'($urandom_range(3));
        if (miss) m_dirty[way] = dirty;
        tp_w = tpw;
        tp_r = tpr;
        drive_dp();
        if (miss) exp_misses = sat_inc(exp_misses);
        e.lat    = miss ? (1 + tpr + (dirty ? tpw : 0)) : 0;
        e.wr     = wr;
        e.way    = way;
        e.miss   = miss;
        e.hits   = exp_hits;
        e.misses = exp_misses;
        e.n_pw   = (miss && dirty) ? tpw : 0;
        e.n_pr   = miss ? tpr : 0;
        e.start  = cyc;
        sb.push_back(e);
        if (!miss) exp_hits = sat_inc(exp_hits);
        i_mem_read  = rd;
        i_mem_write = wr;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            got = cap_resp;
        end
        if (!got) begin
            chk("resp_timeout", 0, 1);
            sb.delete();
        end
        i_mem_read  = 1'b0;
        i_mem_write = 1'b0;
        i_pmem_resp = 1'($urandom_range(1));
        step();
        chk("idle_quiet", int'(cap_any), 0);
    endtask

    initial begin
        bit seen;
        drive_dp();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        step();
        chk("reset_quiet", int'(cap_any), 0);
        chk("reset_hit_count", int'(o_hit_count), 0);
        chk("reset_miss_count", int'(o_miss_count), 0);

        // Directed hits from the spec examples.
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1);
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
        // Clean read miss into way 1, then dirty write miss into way 0.
        run_txn(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 5);
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, 2);
        chk("write_miss_dirty", int'(m_dirty[0]), 1);

        // Reset while writing back a dirty victim.
        m_present = 2; m_lru = 1'b0; m_dirty = 2'b01; tp_w = 100;
        drive_dp();
        i_mem_write = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            step();
            seen = o_pmem_write;
        end
        chk("wb_entered", int'(o_pmem_write), 1);
        chk("wb_addr_sel", int'(o_pmem_address_sel), 1);
        i_rst = 1'b1;
        i_mem_write = 1'b0;
        step();
        chk("rst_wb_pmem_write", int'(o_pmem_write), 0);
        chk("rst_wb_hit_count", int'(o_hit_count), 0);
        chk("rst_wb_miss_count", int'(o_miss_count), 0);
        i_rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        step();
        chk("post_rst_quiet", int'(cap_any), 0);

        // Request withdrawn mid-allocate: fill still completes, then a fresh hit counts.
        m_present = 2; m_lru = 1'b1; m_dirty = 2'b00; tp_r = 4;
        drive_dp();
        i_mem_read = 1'b1;
        exp_misses = sat_inc(exp_misses);
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            step();
            seen = o_pmem_read;
        end
        chk("wd_alloc_entered", int'(o_pmem_read), 1);
        i_mem_read = 1'b0;
        for (int k = 0; k < 20 && o_pmem_read; k++) step();
        chk("wd_alloc_done", int'(o_pmem_read), 0);
        chk("wd_tag_way", m_present, 1);
        step();
        chk("wd_idle_quiet", int'(cap_any), 0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1);
        run_txn(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1);

        // Random traffic; enough of it to drive both counters into saturation.
        for (int t = 0; t < 80; t++) begin
            bit miss, way, wr, rd;
            miss = 1'($urandom_range(1));
            way  = 1'($urandom_range(1));
            wr   = 1'($urandom_range(1));
            rd   = wr ? 1'($urandom_range(1)) : 1'b1;
            run_txn(miss, way, wr, rd, 1'($urandom_range(1)),
                    int'($urandom_range(6, 1)), int'($urandom_range(6, 1)));
        end
        chk("sat_hit_count", int'(o_hit_count), MAX);
        chk("sat_miss_count", int'(o_miss_count), MAX);
        chk("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0, expected 1");
        $fatal(1);
    end

endmodule
